// File: rtl/mux21_pkg.sv
// Shared types and select encodings for the two-requester round-robin mux arbiter.
package mux21_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux21_w.sv
// Purely combinational 2:1 mux; s=SEL_A passes a, s=SEL_B passes b.
module mux21_w
  import mux21_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = (s == SEL_B) ? b : a;

endmodule

// File: rtl/mux21_rr_arbiter.sv
// Round-robin arbiter sharing one registered 2:1 mux between two valid/ready
// requesters, with burst ownership bounded by MAX_BURST under contention.
module mux21_rr_arbiter
  import mux21_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             s
);

  // MAX_BURST=1 would give a zero-width counter; keep one bit that stays at zero.
  localparam int            CW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  arb_state_t       r_state;
  logic             r_sel;
  logic             r_last;
  logic [CW-1:0]    r_count;
  logic             r_y_valid;
  logic [WIDTH-1:0] r_y_data;

  logic             w_space;
  logic             w_a_xfer;
  logic             w_b_xfer;
  logic             w_burst_done;
  logic [WIDTH-1:0] w_mux_y;

  assign w_space      = !r_y_valid || y_ready;
  assign a_ready      = (r_state == OWN_A) && w_space;
  assign b_ready      = (r_state == OWN_B) && w_space;
  assign w_a_xfer     = a_valid && a_ready;
  assign w_b_xfer     = b_valid && b_ready;
  assign w_burst_done = (r_count == LAST);

  assign s       = r_sel;
  assign y_valid = r_y_valid;
  assign y_data  = r_y_data;

  mux21_w #(.WIDTH(WIDTH)) u_mux (
    .a (a_data),
    .b (b_data),
    .s (r_sel),
    .y (w_mux_y)
  );

  // NOTE: state registers use non-blocking assignments so every branch reads
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= SEL_A;
      r_last  <= SEL_B;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (a_valid && (!b_valid || r_last == SEL_B)) begin
            r_state <= OWN_A;
            r_sel   <= SEL_A;
          end else if (b_valid) begin
            r_state <= OWN_B;
            r_sel   <= SEL_B;
          end
        end
        OWN_A: begin
          if (w_a_xfer) begin
            if (w_burst_done && b_valid) begin
              r_state <= OWN_B;
              r_sel   <= SEL_B;
              r_last  <= SEL_A;
              r_count <= '0;
            end else if (!w_burst_done) begin
              r_count <= r_count + 1'b1;
            end
          end else if (!a_valid) begin
            r_last  <= SEL_A;
            r_count <= '0;
            r_state <= b_valid ? OWN_B : IDLE;
            r_sel   <= b_valid ? SEL_B : SEL_A;
          end
        end
        OWN_B: begin
          if (w_b_xfer) begin
            if (w_burst_done && a_valid) begin
              r_state <= OWN_A;
              r_sel   <= SEL_A;
              r_last  <= SEL_B;
              r_count <= '0;
            end else if (!w_burst_done) begin
              r_count <= r_count + 1'b1;
            end
          end else if (!b_valid) begin
            r_last  <= SEL_B;
            r_count <= '0;
            r_state <= a_valid ? OWN_A : IDLE;
            r_sel   <= SEL_A;
          end
        end
        default: begin
          r_state <= IDLE;
          r_sel   <= SEL_A;
          r_count <= '0;
        end
      endcase
    end
  end

  // Output register: reload on any transfer, otherwise drain on y_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
    end else if (w_a_xfer || w_b_xfer) begin
      r_y_valid <= 1'b1;
      r_y_data  <= w_mux_y;
    end else if (y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Scoreboard bench for mux21_rr_arbiter: accepted inputs are queued and matched
// against consumed outputs, plus fixed arbitration-order and handshake checks.
module tb_mux21_rr_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, b_valid, y_ready;
  logic [WIDTH-1:0] a_data, b_data, y_data;
  logic             a_ready, b_ready, y_valid, s;

  always #5 clk = ~clk;

  mux21_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_ready (y_ready),
    .s       (s)
  );

  int               n_vec = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] got_q[$];
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: handshake bookkeeping just before the edge, data advance on the next negedge.
  task automatic tick();
    logic             a_acc;
    logic             b_acc;
    logic [WIDTH-1:0] exp;
    #1;
    a_acc = 1'b0;
    b_acc = 1'b0;
    if (!rst) begin
      if (y_valid && y_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          exp = sb_q.pop_front();
          check("sb", 32'(y_data), 32'(exp));
        end
        got_q.push_back(y_data);
      end
      if (a_valid && a_ready) begin
        sb_q.push_back(a_data);
        a_acc = 1'b1;
      end
      if (b_valid && b_ready) begin
        sb_q.push_back(b_data);
        b_acc = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (a_acc) a_data = a_data + 1'b1;
    if (b_acc) b_data = b_data + 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    got_q.delete();
  endtask

  task automatic check_got(input string tag);
    check({tag, "_count"}, 32'(got_q.size() >= exp_q.size()), 32'd1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check(tag, 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    // Reset held two cycles with both requesters valid.
    rst     = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    y_ready = 1'b1;
    a_data  = 8'h10;
    b_data  = 8'h20;
    tick();
    #1;
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_y_data",  32'(y_data),  32'd0);
    check("rst_s",       32'(s),       32'd0);
    tick();
    rst = 1'b0;

    // Contention: bursts of four alternate after one IDLE bubble, A first.
    #1;
    check("t2_bubble_a_ready", 32'(a_ready), 32'd0);
    tick();
    repeat (19) tick();
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23,
              8'h14, 8'h15, 8'h16, 8'h17};
    check_got("t2_order");

    // Backpressure mid-burst: count frozen, burst resumes after the stall.
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    a_data  = 8'h30; b_data  = 8'h40;
    repeat (3) tick();
    y_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_a_ready", 32'(a_ready), 32'd0);
      check("t3_y_hold",  32'(y_data),  32'h31);
      check("t3_y_valid", 32'(y_valid), 32'd1);
      tick();
    end
    y_ready = 1'b1;
    repeat (9) tick();
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h42, 8'h43, 8'h34};
    check_got("t3_order");

    // Sole requester B keeps ownership with no further bubbles.
    do_reset();
    a_valid = 1'b0; b_valid = 1'b1; y_ready = 1'b1;
    a_data  = 8'h00; b_data  = 8'h50;
    tick();
    for (int i = 0; i < 11; i++) begin
      #1;
      check("t4_s",       32'(s),       32'd1);
      check("t4_b_ready", 32'(b_ready), 32'd1);
      tick();
    end
    exp_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59};
    check_got("t4_order");

    // A drops valid after two transfers: B takes over with no bubble.
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    a_data  = 8'h60; b_data  = 8'h70;
    repeat (3) tick();
    a_valid = 1'b0;
    #1;
    check("t5_s_before",   32'(s),       32'd0);
    check("t5_b_ready_0",  32'(b_ready), 32'd0);
    tick();
    #1;
    check("t5_s_own_b",    32'(s),       32'd1);
    check("t5_b_ready_1",  32'(b_ready), 32'd1);
    tick();
    #1;
    check("t5_y_valid",    32'(y_valid), 32'd1);
    check("t5_y_data",     32'(y_data),  32'h70);
    b_valid = 1'b0;
    tick();
    exp_q = '{8'h60, 8'h61, 8'h70};
    check_got("t5_order");

    // Reset while B owns and output is stalled: register cleared, next tie to A.
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    a_data  = 8'h80; b_data  = 8'h90;
    repeat (6) tick();
    y_ready = 1'b0;
    #1;
    check("t6_pre_y_valid", 32'(y_valid), 32'd1);
    check("t6_pre_s",       32'(s),       32'd1);
    tick();
    do_reset();
    y_ready = 1'b1;
    #1;
    check("t6_y_valid",  32'(y_valid), 32'd0);
    check("t6_y_data",   32'(y_data),  32'd0);
    check("t6_a_ready",  32'(a_ready), 32'd0);
    check("t6_b_ready",  32'(b_ready), 32'd0);
    check("t6_s_idle",   32'(s),       32'd0);
    tick();
    #1;
    check("t6_tie_s",       32'(s),       32'd0);
    check("t6_tie_a_ready", 32'(a_ready), 32'd1);
    tick();
    #1;
    check("t6_first_y", 32'(y_data), 32'h84);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
